// File: rtl/block_stream_gen.sv
// block_stream_gen: turns BEGIN/END/CHAR/SPACE commands into a space-terminated ASCII byte stream
// and tracks block nesting depth. Optional build macro MIXED_CASE_EN randomises letter case via an LFSR.
module block_stream_gen #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic [7:0]         cmd_char,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow,
  output logic               balanced
);

  localparam logic [1:0] CMD_BEGIN = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b01;
  localparam logic [1:0] CMD_CHAR  = 2'b10;
  localparam logic [1:0] CMD_SPACE = 2'b11;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_nxt;
  logic [1:0]   tok, tok_nxt;
  logic [7:0]   tok_char, tok_char_nxt;
  logic [2:0]   idx, idx_nxt;
  logic         at_last;
  logic         accept;
  logic         emit_nxt;
  logic [7:0]   byte_nxt;
  logic [7:0]   case_mask;
  logic [DEPTH_W-1:0] depth_nxt;
  logic         underflow_nxt;
  logic         overflow_nxt;

  // Index of the trailing space for each token kind.
  function automatic logic [2:0] last_idx(input logic [1:0] t);
    case (t)
      CMD_BEGIN: last_idx = 3'd5;
      CMD_END:   last_idx = 3'd3;
      CMD_CHAR:  last_idx = 3'd1;
      default:   last_idx = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] token_byte(input logic [1:0] t, input logic [7:0] c,
                                            input logic [2:0] i);
    token_byte = 8'h20;
    case (t)
      CMD_BEGIN:
        case (i)
          3'd0:    token_byte = 8'h62;
          3'd1:    token_byte = 8'h65;
          3'd2:    token_byte = 8'h67;
          3'd3:    token_byte = 8'h69;
          3'd4:    token_byte = 8'h6E;
          default: token_byte = 8'h20;
        endcase
      CMD_END:
        case (i)
          3'd0:    token_byte = 8'h65;
          3'd1:    token_byte = 8'h6E;
          3'd2:    token_byte = 8'h64;
          default: token_byte = 8'h20;
        endcase
      CMD_CHAR:  token_byte = (i == 3'd0) ? c : 8'h20;
      CMD_SPACE: token_byte = 8'h20;
      default:   token_byte = 8'h20;
    endcase
  endfunction

  assign at_last = (state == EMIT) && (idx == last_idx(tok));
  assign accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The trailing-space cycle doubles as an acceptance slot so tokens can run back to back.
  always_comb begin
    state_nxt    = state;
    tok_nxt      = tok;
    tok_char_nxt = tok_char;
    idx_nxt      = idx;
    emit_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = EMIT;
          tok_nxt      = cmd;
          tok_char_nxt = cmd_char;
          idx_nxt      = 3'd0;
          emit_nxt     = 1'b1;
        end
      end
      EMIT: begin
        if (at_last) begin
          if (accept) begin
            tok_nxt      = cmd;
            tok_char_nxt = cmd_char;
            idx_nxt      = 3'd0;
            emit_nxt     = 1'b1;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
          end
        end else begin
          idx_nxt  = idx + 3'd1;
          emit_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state == IDLE) || at_last;
    byte_nxt      = emit_nxt ? (token_byte(tok_nxt, tok_char_nxt, idx_nxt) ^ case_mask) : 8'h20;
    depth_nxt     = depth;
    underflow_nxt = underflow;
    overflow_nxt  = overflow;
    if (at_last && tok == CMD_BEGIN) begin
      if (depth == DEPTH_MAX) overflow_nxt = 1'b1;
      else                    depth_nxt    = depth + DEPTH_ONE;
    end else if (at_last && tok == CMD_END) begin
      if (depth == '0) underflow_nxt = 1'b1;
      else             depth_nxt     = depth - DEPTH_ONE;
    end
  end

`ifdef MIXED_CASE_EN
  logic [7:0] lfsr;
  logic       letter_nxt;

  // Only BEGIN/END letters consume LFSR steps; CHAR bytes and spaces pass through untouched.
  assign letter_nxt = emit_nxt &&
                      (((tok_nxt == CMD_BEGIN) && (idx_nxt != 3'd5)) ||
                       ((tok_nxt == CMD_END)   && (idx_nxt != 3'd3)));
  assign case_mask  = (letter_nxt && lfsr[0]) ? 8'h20 : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          lfsr <= 8'hA5;
    else if (letter_nxt) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign case_mask = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok       <= CMD_SPACE;
      tok_char  <= 8'h20;
      idx       <= 3'd0;
      out       <= 8'h20;
      out_valid <= 1'b0;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      balanced  <= 1'b1;
    end else begin
      tok       <= tok_nxt;
      tok_char  <= tok_char_nxt;
      idx       <= idx_nxt;
      out       <= byte_nxt;
      out_valid <= emit_nxt;
      depth     <= depth_nxt;
      underflow <= underflow_nxt;
      overflow  <= overflow_nxt;
      balanced  <= (depth_nxt == '0) && !underflow_nxt;
    end
  end

endmodule
